// File: rtl/word_sop_pkg.sv
// word_sop_pkg: shared FSM state type and operand preprocessing constants.
package word_sop_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL0  = 3'd1,
    MUL1  = 3'd2,
    MUL2  = 3'd3,
    SCALE = 3'd4,
    DONE  = 3'd5
  } state_t;
  localparam logic [7:0] B_XOR = 8'h69;
  localparam logic [3:0] S_XOR = 4'h6;
  localparam int unsigned E_SHR = 3;
  localparam int unsigned F_SHL = 3;
endpackage

// File: rtl/word_sop_prep.sv
// word_sop_prep: combinational mapping of latched operands to a'..f' and s'.
module word_sop_prep
  import word_sop_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic [7:0] e,
  input  logic [7:0] f,
  input  logic [3:0] s,
  output logic [7:0] ap,
  output logic [7:0] bp,
  output logic [7:0] cp,
  output logic [7:0] dp,
  output logic [7:0] ep,
  output logic [7:0] fp,
  output logic [3:0] sp
);
  assign ap = -a;
  assign bp = b ^ B_XOR;
  assign cp = {{4{c[7]}}, {4{c[3]}}};
  assign dp = ~d;
  assign ep = e >> E_SHR;
  assign fp = f << F_SHL;
  assign sp = -(s ^ S_XOR);
endmodule

// File: rtl/word_sop_seq.sv
// word_sop_seq: g = s'*(a'b' + c'd' + e'f') computed over four cycles on one shared multiplier.
module word_sop_seq
  import word_sop_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [7:0]       c,
  input  logic [7:0]       d,
  input  logic [7:0]       e,
  input  logic [7:0]       f,
  input  logic [3:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] g,
  output logic             busy
);
  state_t state;
  logic [7:0] ra, rb, rc, rd, re, rf;
  logic [3:0] rs;
  logic [7:0] ap, bp, cp, dp, ep, fp;
  logic [3:0] sp;
  logic [OUT_W-1:0] acc, m_x, m_y, prod;

  word_sop_prep u_prep (
    .a(ra), .b(rb), .c(rc), .d(rd), .e(re), .f(rf), .s(rs),
    .ap(ap), .bp(bp), .cp(cp), .dp(dp), .ep(ep), .fp(fp), .sp(sp)
  );

  // the single multiplier: operands steered by the current step
  always_comb begin
    m_x = state == MUL0 ? OUT_W'(ap) : state == MUL1 ? OUT_W'(cp) : state == MUL2 ? OUT_W'(ep) : acc;
    m_y = state == MUL0 ? OUT_W'(bp) : state == MUL1 ? OUT_W'(dp) : state == MUL2 ? OUT_W'(fp) : OUT_W'(sp);
    prod = m_x * m_y;
  end

  assign in_ready = state == IDLE;
  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      g <= '0;
      out_valid <= 1'b0;
      {ra, rb, rc, rd, re, rf} <= '0;
      rs <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {ra, rb, rc, rd, re, rf} <= {a, b, c, d, e, f};
          rs <= s;
          state <= MUL0;
        end
        MUL0: begin
          acc <= prod;
          state <= MUL1;
        end
        MUL1: begin
          acc <= acc + prod;
          state <= MUL2;
        end
        MUL2: begin
          acc <= acc + prod;
          state <= SCALE;
        end
        SCALE: begin
          g <= prod;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_word_sop_seq.sv
// tb_word_sop_seq: directed and randomized checks of word_sop_seq against an arithmetic model.
module tb_word_sop_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] a = 0, b = 0, c = 0, d = 0, e = 0, f = 0;
  logic [3:0] s = 0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] g;
  logic busy;
  int checks = 0;
  int failures = 0;

  word_sop_seq #(.OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .s(s),
    .out_valid(out_valid), .out_ready(out_ready), .g(g), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int model(input int ia, ib, ic, id, ie, ifv, is);
    int ap, bp, cp, dp, ep, fp, sp;
    ap = (256 - ia) % 256;
    bp = ib ^ 'h69;
    cp = (ic[7] ? 'hF0 : 0) | (ic[3] ? 'h0F : 0);
    dp = 255 - id;
    ep = ie / 8;
    fp = (ifv * 8) % 256;
    sp = (16 - (is ^ 6)) % 16;
    return ((ap * bp + cp * dp + ep * fp) * sp) % 65536;
  endfunction

  task automatic set_ops(input int ia, ib, ic, id, ie, ifv, is);
    a = 8'(ia); b = 8'(ib); c = 8'(ic); d = 8'(id); e = 8'(ie); f = 8'(ifv); s = 4'(is);
  endtask

  task automatic send(input int ia, ib, ic, id, ie, ifv, is);
    @(negedge clk);
    set_ops(ia, ib, ic, id, ie, ifv, is);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 30) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, g} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL reset: rdy/ov/busy/g=%b%b%b/%h required 100/0000", in_ready, out_valid, busy, g);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    int tv [3][7] = '{'{'hFF, 'h68, 'h08, 'hFE, 'h10, 'h01, 7},
                      '{'hFF, 'h68, 'h08, 'hFE, 'h10, 'h01, 6},
                      '{'h80, 'h96, 'h88, 'h00, 'hFF, 'hFF, 0}};
    logic [15:0] req [3] = '{16'h01E0, 16'h0000, 16'h135A};
    int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5], tv[i][6]);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_accept: busy=%b in_ready=%b required 1/0", i, busy, in_ready);
      end
      wait_out(cyc);
      checks++;
      if (cyc !== 4) begin
        failures++;
        $display("FAIL vec%0d_latency: %0d cycles required 4", i, cyc);
      end
      checks++;
      if (g !== req[i]) begin
        failures++;
        $display("FAIL vec%0d_g: g=%h required %h", i, g, req[i]);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || g !== req[i]) begin
        failures++;
        $display("FAIL vec%0d_handoff: ov=%b rdy=%b g=%h required 0/1/%h", i, out_valid, in_ready, g, req[i]);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int cyc, bad;
    logic [15:0] r1, r2;
    r1 = 16'(model('h12, 'h34, 'h56, 'h78, 'h9A, 'hBC, 3));
    r2 = 16'(model('hA5, 'h5A, 'hC3, 'h3C, 'hF0, 'h0F, 9));
    out_ready = 1'b0;
    send('h12, 'h34, 'h56, 'h78, 'h9A, 'hBC, 3);
    wait_out(cyc);
    set_ops('hA5, 'h5A, 'hC3, 'h3C, 'hF0, 'h0F, 9);
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (g !== r1 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || cyc != 4) begin
      failures++;
      $display("FAIL bp_hold: %0d bad cycles, latency %0d, g=%h required 0 bad, 4, %h", bad, cyc, g, r1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || g !== r1) begin
      failures++;
      $display("FAIL bp_handoff: ov=%b rdy=%b g=%h required 0/1/%h", out_valid, in_ready, g, r1);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_accept: busy=%b required 1", busy);
    end
    wait_out(cyc);
    checks++;
    if (g !== r2 || cyc != 4) begin
      failures++;
      $display("FAIL bp_second: g=%h latency %0d required %h, 4", g, cyc, r2);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [15:0] r;
    r = 16'(model('h80, 'h96, 'h88, 'h00, 'hFF, 'hFF, 0));
    send('h11, 'h22, 'h33, 'h44, 'h55, 'h66, 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, g} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL reset_mid: rdy/ov/busy/g=%b%b%b/%h required 100/0000", in_ready, out_valid, busy, g);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send('h80, 'h96, 'h88, 'h00, 'hFF, 'hFF, 0);
    wait_out(cyc);
    checks++;
    if (g !== r || cyc != 4) begin
      failures++;
      $display("FAIL reset_mid_after: g=%h latency %0d required %h, 4", g, cyc, r);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    int exp_q[$];
    int acc_n = 0, res_n = 0, cyc = 0;
    int ia, ib, ic, id, ie, ifv, is;
    @(negedge clk);
    while ((acc_n < 10000 || exp_q.size() != 0) && cyc < 95000) begin
      ia = $urandom_range(255); ib = $urandom_range(255); ic = $urandom_range(255);
      id = $urandom_range(255); ie = $urandom_range(255); ifv = $urandom_range(255);
      is = $urandom_range(15);
      set_ops(ia, ib, ic, id, ie, ifv, is);
      in_valid = acc_n < 10000;
      out_ready = $urandom_range(1) == 1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ia, ib, ic, id, ie, ifv, is));
        acc_n++;
      end
      if (out_valid && out_ready) begin
        res_n++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra: result %h with no pending accept", g);
        end else if (g !== 16'(exp_q[0])) begin
          failures++;
          $display("FAIL rand_g: result %0d g=%h required %h", res_n, g, 16'(exp_q[0]));
          void'(exp_q.pop_front());
        end else
          void'(exp_q.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (acc_n != res_n || acc_n != 10000) begin
      failures++;
      $display("FAIL rand_count: accepts=%0d results=%0d required 10000/10000", acc_n, res_n);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
